regfile_param_sb: RTL and testbench

//   Parametrised multi-read register file with write-to-read bypass and a per-register

---
 rtl/regfile_param_sb.sv | 60 ++++++
 tb/tb_regfile_param_sb.sv | 93 +++++++++
 2 files changed

// File: rtl/regfile_param_sb.sv
// regfile_param_sb: multi-read register file with write bypass and busy scoreboard
module regfile_param_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter bit BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   busy_cnt
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [ADDR_W:0] busy_cnt_q, busy_cnt_d;
    logic wr_ok, byp1, byp2;
    always_comb begin
        wr_ok = wr_en && (wr_addr != '0);
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        // a reservation in the same cycle as the write marks a new producer, so it wins
        if (rsv_en) busy_d[rsv_addr] = 1'b1;
        busy_d[0] = 1'b0;
        busy_cnt_d = '0;
        for (int i = 0; i < NUM_REGS; i++) busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end
    assign byp1 = BYPASS && wr_ok && (wr_addr == rd_addr1);
    assign byp2 = BYPASS && wr_ok && (wr_addr == rd_addr2);
    assign rd_data1 = byp1 ? wr_data : regs_q[rd_addr1];
    assign rd_data2 = byp2 ? wr_data : regs_q[rd_addr2];
    assign busy1 = byp1 ? 1'b0 : busy_q[rd_addr1];
    assign busy2 = byp2 ? 1'b0 : busy_q[rd_addr2];
    assign busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_regfile_param_sb.sv
// tb_regfile_param_sb: scoreboard bench for regfile_param_sb with directed vectors
module tb_regfile_param_sb;
    logic clk = 0, rst = 1;
    logic [3:0] rd_addr1 = 0, rd_addr2 = 0, wr_addr = 0, rsv_addr = 0;
    logic [15:0] rd_data1, rd_data2, wr_data = 0;
    logic wr_en = 0, rsv_en = 0, busy1, busy2;
    logic [4:0] busy_cnt;
    int total = 0, bad = 0;

    typedef struct {
        string nm;
        logic [15:0] d1, d2;
        logic b1, b2;
        logic [4:0] c;
    } exp_t;
    exp_t q[$];

    regfile_param_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (rd_data1 !== e.d1 || rd_data2 !== e.d2 || busy1 !== e.b1 || busy2 !== e.b2 || busy_cnt !== e.c) begin
                bad++;
                $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b cnt=%0d, want d1=%h d2=%h b1=%b b2=%b cnt=%0d",
                         e.nm, rd_data1, rd_data2, busy1, busy2, busy_cnt, e.d1, e.d2, e.b1, e.b2, e.c);
            end
        end
    end

    task automatic vec(input string nm, input logic r, input logic we, input logic [3:0] wa,
                       input logic [15:0] wd, input logic re, input logic [3:0] ra,
                       input logic [3:0] a1, input logic [3:0] a2, input logic [15:0] e1,
                       input logic [15:0] e2, input logic eb1, input logic eb2, input logic [4:0] ec);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rsv_en = re; rsv_addr = ra;
        rd_addr1 = a1; rd_addr2 = a2;
        q.push_back('{nm, e1, e2, eb1, eb2, ec});
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        rst = 0;
        for (int a = 0; a < 16; a++) vec("rst_read", 0, 0, 0, 0, 0, 0, 4'(a), 4'(15 - a), 0, 0, 0, 0, 0);
        vec("wr_r5_byp",   0, 1, 5, 16'hA5A5, 0, 0, 5, 5, 16'hA5A5, 16'hA5A5, 0, 0, 0);
        vec("rd_r5",       0, 0, 0, 0,        0, 0, 5, 5, 16'hA5A5, 16'hA5A5, 0, 0, 0);
        vec("wr_r0",       0, 1, 0, 16'hFFFF, 0, 0, 0, 5, 16'h0000, 16'hA5A5, 0, 0, 0);
        vec("rd_r0",       0, 0, 0, 0,        0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        vec("wr_r3_byp",   0, 1, 3, 16'h1234, 0, 0, 5, 3, 16'hA5A5, 16'h1234, 0, 0, 0);
        vec("rd_r3",       0, 0, 0, 0,        0, 0, 5, 3, 16'hA5A5, 16'h1234, 0, 0, 0);
        vec("rsv_r7",      0, 0, 0, 0,        1, 7, 7, 0, 16'h0000, 16'h0000, 0, 0, 0);
        vec("r7_busy",     0, 0, 0, 0,        0, 0, 7, 0, 16'h0000, 16'h0000, 1, 0, 1);
        vec("wr_r7_byp",   0, 1, 7, 16'h0777, 0, 0, 7, 7, 16'h0777, 16'h0777, 0, 0, 1);
        vec("r7_clear",    0, 0, 0, 0,        0, 0, 7, 7, 16'h0777, 16'h0777, 0, 0, 0);
        vec("rsv_wr_r4",   0, 1, 4, 16'h0042, 1, 4, 4, 0, 16'h0042, 16'h0000, 0, 0, 0);
        vec("r4_busy",     0, 0, 0, 0,        0, 0, 4, 0, 16'h0042, 16'h0000, 1, 0, 1);
        vec("rsv_r9",      0, 0, 0, 0,        1, 9, 9, 4, 16'h0000, 16'h0042, 0, 1, 1);
        vec("r9_busy",     0, 0, 0, 0,        0, 0, 9, 4, 16'h0000, 16'h0042, 1, 1, 2);
        vec("rsv2_wr9",    0, 1, 9, 16'h0909, 1, 2, 2, 9, 16'h0000, 16'h0909, 0, 0, 2);
        vec("net_zero",    0, 0, 0, 0,        0, 0, 2, 9, 16'h0000, 16'h0909, 1, 0, 2);
        vec("rsv_r4_again",0, 0, 0, 0,        1, 4, 4, 0, 16'h0042, 16'h0000, 1, 0, 2);
        vec("rsv_r0",      0, 0, 0, 0,        1, 0, 4, 0, 16'h0042, 16'h0000, 1, 0, 2);
        vec("r0_not_busy", 0, 0, 0, 0,        0, 0, 0, 4, 16'h0000, 16'h0042, 0, 1, 2);
        vec("rsv_r1",      0, 0, 0, 0,        1, 1, 1, 0, 16'h0000, 16'h0000, 0, 0, 2);
        vec("rsv_r2",      0, 0, 0, 0,        1, 2, 1, 0, 16'h0000, 16'h0000, 1, 0, 3);
        vec("rsv_r3",      0, 0, 0, 0,        1, 3, 3, 0, 16'h1234, 16'h0000, 0, 0, 3);
        vec("rsv_r4",      0, 0, 0, 0,        1, 4, 3, 0, 16'h1234, 16'h0000, 1, 0, 4);
        vec("rsv_r5",      0, 0, 0, 0,        1, 5, 5, 0, 16'hA5A5, 16'h0000, 0, 0, 4);
        vec("rsv_r6",      0, 0, 0, 0,        1, 6, 5, 0, 16'hA5A5, 16'h0000, 1, 0, 5);
        vec("rst_prio",    1, 1, 8, 16'h8888, 1, 7, 6, 3, 16'h0000, 16'h1234, 1, 1, 6);
        for (int a = 0; a < 16; a++) vec("post_rst", 0, 0, 0, 0, 0, 0, 4'(a), 4'(15 - a), 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
